// File: rtl/cpu_pkg.sv
// Shared datapath definitions for the decode stage, the register file and the ALU.
// Provides the default data width and register count, the register index
// constants and the address/data typedefs.
package cpu_pkg;

   localparam int DATA_W  = 10;
   localparam int REG_CNT = 4;
   localparam int REG_AW  = $clog2(REG_CNT);

   typedef logic [REG_AW-1:0] reg_addr_t;
   typedef logic [DATA_W-1:0] reg_data_t;

   localparam reg_addr_t R0 = reg_addr_t'(0);
   localparam reg_addr_t R1 = reg_addr_t'(1);
   localparam reg_addr_t R2 = reg_addr_t'(2);
   localparam reg_addr_t R3 = reg_addr_t'(3);

endpackage

// File: rtl/reg_file_nbit_if.sv
// Register-file access bundle: one write port and two read ports.
//   master : decode/writeback side, drives the write port and read addresses
//   slave  : register file, returns the two read data words
// Signals:
//   wen      write enable
//   waddr    write register index (AW bits)
//   wdata    write data (WIDTH bits)
//   raddr_a  read port A index
//   raddr_b  read port B index
//   rdata_a  read port A data
//   rdata_b  read port B data
interface reg_file_nbit_if
   import cpu_pkg::*;
#(
   parameter int WIDTH = DATA_W,
   parameter int DEPTH = REG_CNT
);
   localparam int AW = $clog2(DEPTH);

   logic             wen;
   logic [AW-1:0]    waddr;
   logic [WIDTH-1:0] wdata;
   logic [AW-1:0]    raddr_a;
   logic [AW-1:0]    raddr_b;
   logic [WIDTH-1:0] rdata_a;
   logic [WIDTH-1:0] rdata_b;

   modport master (
      output wen, waddr, wdata, raddr_a, raddr_b,
      input  rdata_a, rdata_b
   );

   modport slave (
      input  wen, waddr, wdata, raddr_a, raddr_b,
      output rdata_a, rdata_b
   );

endinterface

// File: rtl/reg_nbit.sv
// WIDTH-bit storage register with load enable.
// Ports:
//   clk    clock, rising edge
//   rst    asynchronous active-high reset, clears to 0
//   wen_i  load enable
//   d_i    load data
//   q_o    stored value
module reg_nbit
   import cpu_pkg::*;
#(
   parameter int WIDTH = DATA_W
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             wen_i,
   input  logic [WIDTH-1:0] d_i,
   output logic [WIDTH-1:0] q_o
);

   logic [WIDTH-1:0] data_q;
   logic [WIDTH-1:0] data_d;

   always_comb begin
      data_d = wen_i ? d_i : data_q;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         data_q <= '0;
      end else begin
         data_q <= data_d;
      end
   end

   assign q_o = data_q;

endmodule

// File: rtl/reg_file_nbit.sv
// DEPTH x WIDTH register file with one synchronous write port and two
// combinational read ports, feeding both ALU operands in the same cycle.
// Ports:
//   clk  clock, rising edge
//   rst  asynchronous active-high reset, clears all registers
//   bus  reg_file_nbit_if.slave (write port, read addresses, read data)
// Parameters:
//   WIDTH     register width
//   DEPTH     register count (>= 2); indices >= DEPTH are ignored on write, read 0
//   ZERO_REG  1 = index 0 is hardwired to zero
// Build option:
//   REG_FILE_BYPASS_EN  when defined, a legal write is forwarded combinationally
//                       to any read port addressing the same index
module reg_file_nbit
   import cpu_pkg::*;
#(
   parameter int WIDTH    = DATA_W,
   parameter int DEPTH    = REG_CNT,
   parameter bit ZERO_REG = 1'b0
) (
   input  logic          clk,
   input  logic          rst,
   reg_file_nbit_if.slave bus
);

   localparam int AW = $clog2(DEPTH);

   logic [DEPTH-1:0] wen_dec;
   logic [WIDTH-1:0] regs_q [DEPTH];

   // One-hot write decode; out-of-range indices match nothing, and the
   // hardwired zero register never loads.
   always_comb begin
      wen_dec = '0;
      for (int i = 0; i < DEPTH; i++) begin
         wen_dec[i] = bus.wen && (32'(bus.waddr) == i) && !(ZERO_REG && (i == 0));
      end
   end

   for (genvar g = 0; g < DEPTH; g++) begin : g_reg
      reg_nbit #(.WIDTH(WIDTH)) u_reg (
         .clk   (clk),
         .rst   (rst),
         .wen_i (wen_dec[g]),
         .d_i   (bus.wdata),
         .q_o   (regs_q[g])
      );
   end

`ifdef REG_FILE_BYPASS_EN
   logic fwd_ok;

   // Forward only writes that will actually land, and never during reset.
   always_comb begin
      fwd_ok = !rst && bus.wen && (32'(bus.waddr) < DEPTH)
               && !(ZERO_REG && (bus.waddr == '0));
   end
`endif

   // Read muxes: default 0 covers out-of-range indices and the zero register.
   always_comb begin
      bus.rdata_a = '0;
      bus.rdata_b = '0;
      for (int i = 0; i < DEPTH; i++) begin
         if ((32'(bus.raddr_a) == i) && !(ZERO_REG && (i == 0))) begin
            bus.rdata_a = regs_q[i];
         end
         if ((32'(bus.raddr_b) == i) && !(ZERO_REG && (i == 0))) begin
            bus.rdata_b = regs_q[i];
         end
      end
`ifdef REG_FILE_BYPASS_EN
      if (fwd_ok && (bus.raddr_a == bus.waddr)) begin
         bus.rdata_a = bus.wdata;
      end
      if (fwd_ok && (bus.raddr_b == bus.waddr)) begin
         bus.rdata_b = bus.wdata;
      end
`endif
   end

   wire [AW-1:0] unused_aw_chk = bus.waddr;

endmodule

// File: tb/tb_reg_file_nbit.sv
// Bench for reg_file_nbit. Two instances: a default 10x4 file, and a 16x6 file
// with the zero register enabled (exercises out-of-range indices 6 and 7).
// Build option REG_FILE_BYPASS_EN selects the forwarding behaviour of the model.
module tb_reg_file_nbit;

   localparam int W0 = 10;
   localparam int D0 = 4;
   localparam int W1 = 16;
   localparam int D1 = 6;

   logic clk = 1'b0;
   logic rst;

   always #5 clk = ~clk;

   reg_file_nbit_if #(.WIDTH(W0), .DEPTH(D0)) bus0 ();
   reg_file_nbit_if #(.WIDTH(W1), .DEPTH(D1)) bus1 ();

   reg_file_nbit #(.WIDTH(W0), .DEPTH(D0), .ZERO_REG(1'b0)) dut0 (
      .clk (clk),
      .rst (rst),
      .bus (bus0.slave)
   );

   reg_file_nbit #(.WIDTH(W1), .DEPTH(D1), .ZERO_REG(1'b1)) dut1 (
      .clk (clk),
      .rst (rst),
      .bus (bus1.slave)
   );

   typedef struct {
      int          which;
      string       tag;
      logic [15:0] a;
      logic [15:0] b;
   } exp_t;

   exp_t        exp_q [$];
   int          n_checks = 0;
   int          n_pass   = 0;

   // Reference storage: plain arrays of what each register should hold.
   logic [15:0] m0 [D0];
   logic [15:0] m1 [D1];

   function automatic bit legal(input int which, input int idx);
      if (which == 0) return (idx < D0);
      return (idx < D1) && (idx != 0);
   endfunction

   function automatic logic [15:0] model_rd(input int which, input int idx);
      logic [15:0] v;
      logic        w;
      int          wa;
      logic [15:0] wd;
      v = '0;
      if (which == 0) begin
         if (legal(0, idx)) v = m0[idx];
         w = bus0.wen; wa = int'(bus0.waddr); wd = 16'(bus0.wdata);
      end else begin
         if (legal(1, idx)) v = m1[idx];
         w = bus1.wen; wa = int'(bus1.waddr); wd = 16'(bus1.wdata);
      end
`ifdef REG_FILE_BYPASS_EN
      if (!rst && w && legal(which, wa) && (wa == idx)) v = wd;
`else
      if (w && (wa < 0)) v = wd;
`endif
      return v;
   endfunction

   task automatic model_clear();
      for (int i = 0; i < D0; i++) m0[i] = '0;
      for (int i = 0; i < D1; i++) m1[i] = '0;
   endtask

   task automatic model_commit();
      if (rst) begin
         model_clear();
      end else begin
         if (bus0.wen && legal(0, int'(bus0.waddr))) m0[int'(bus0.waddr)] = 16'(bus0.wdata);
         if (bus1.wen && legal(1, int'(bus1.waddr))) m1[int'(bus1.waddr)] = bus1.wdata;
      end
   endtask

   task automatic push_expect(input string tag);
      exp_t e;
      e.tag   = tag;
      e.which = 0;
      e.a     = model_rd(0, int'(bus0.raddr_a));
      e.b     = model_rd(0, int'(bus0.raddr_b));
      exp_q.push_back(e);
      e.which = 1;
      e.a     = model_rd(1, int'(bus1.raddr_a));
      e.b     = model_rd(1, int'(bus1.raddr_b));
      exp_q.push_back(e);
   endtask

   task automatic tick();
      @(posedge clk);
      model_commit();
      #1;
   endtask

   task automatic set_rst(input logic v);
      rst = v;
      if (v) model_clear();
   endtask

   task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
      n_checks++;
      if (act !== exp) begin
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end else begin
         n_pass++;
      end
   endtask

   // Monitor: outputs are combinational, so they are sampled mid-cycle on the
   // falling edge, after all stimulus for the cycle has settled.
   always @(negedge clk) begin
      exp_t e;
      while (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         if (e.which == 0) begin
            check($sformatf("%s dut0 rdata_a", e.tag), 16'(bus0.rdata_a), e.a);
            check($sformatf("%s dut0 rdata_b", e.tag), 16'(bus0.rdata_b), e.b);
         end else begin
            check($sformatf("%s dut1 rdata_a", e.tag), bus1.rdata_a, e.a);
            check($sformatf("%s dut1 rdata_b", e.tag), bus1.rdata_b, e.b);
         end
      end
   end

   task automatic idle_both();
      bus0.wen = 1'b0;
      bus1.wen = 1'b0;
   endtask

   initial begin
      set_rst(1'b1);
      bus0.wen = 1'b0; bus0.waddr = '0; bus0.wdata = '0; bus0.raddr_a = '0; bus0.raddr_b = '0;
      bus1.wen = 1'b0; bus1.waddr = '0; bus1.wdata = '0; bus1.raddr_a = '0; bus1.raddr_b = '0;
      #2;
      push_expect("reset");
      tick();
      push_expect("reset_hold");
      tick();
      set_rst(1'b0);

      // Load reg1 = 155 in both files, then pulse reset mid-cycle.
      bus0.wen = 1'b1; bus0.waddr = 2'd1; bus0.wdata = 10'h155;
      bus1.wen = 1'b1; bus1.waddr = 3'd1; bus1.wdata = 16'h0155;
      push_expect("load_r1_pre");
      tick();
      idle_both();
      bus0.raddr_a = 2'd1; bus1.raddr_a = 3'd1;
      push_expect("load_r1");
      tick();
      #1;
      set_rst(1'b1);
      push_expect("rst_async");
      @(negedge clk);
      #2;
      set_rst(1'b0);
      tick();
      push_expect("rst_after");
      tick();

      // A write on an edge where reset is high is lost.
      bus0.wen = 1'b1; bus0.waddr = 2'd2; bus0.wdata = 10'h2C3;
      set_rst(1'b1);
      tick();
      set_rst(1'b0);
      idle_both();
      bus0.raddr_a = 2'd2;
      push_expect("write_in_rst");
      tick();

      // Reload reg1, then hold with wen=0 for three cycles.
      bus0.wen = 1'b1; bus0.waddr = 2'd1; bus0.wdata = 10'h155;
      tick();
      bus0.wen = 1'b0; bus0.wdata = 10'h2AA; bus0.raddr_a = 2'd1;
      for (int i = 0; i < 3; i++) begin
         push_expect("hold_r1");
         tick();
      end
      push_expect("hold_r1_end");

      // Back-to-back writes, read both together.
      bus0.wen = 1'b1; bus0.waddr = 2'd2; bus0.wdata = 10'h3FF;
      tick();
      bus0.waddr = 2'd3; bus0.wdata = 10'h001;
      tick();
      bus0.wen = 1'b0; bus0.raddr_a = 2'd2; bus0.raddr_b = 2'd3;
      push_expect("pair_read");
      tick();

      // Same-cycle read and write of one index.
      bus0.wen = 1'b1; bus0.waddr = 2'd2; bus0.wdata = 10'h0F0; bus0.raddr_a = 2'd2;
      push_expect("rw_same_pre");
      tick();
      bus0.wen = 1'b0;
      push_expect("rw_same_post");
      tick();

      // Zero register on dut1, including same-cycle read of the written index.
      bus1.wen = 1'b1; bus1.waddr = 3'd0; bus1.wdata = 16'h0123; bus1.raddr_a = 3'd0;
      push_expect("zero_reg_pre");
      tick();
      bus1.wen = 1'b0;
      push_expect("zero_reg_post");
      tick();

      // Fill dut1, then write an out-of-range index and sweep all registers.
      for (int i = 1; i < D1; i++) begin
         bus1.wen = 1'b1; bus1.waddr = 3'(i); bus1.wdata = 16'(16'h1000 + i * 16'h0111);
         tick();
      end
      bus1.wen = 1'b1; bus1.waddr = 3'd7; bus1.wdata = 16'hBEEF;
      bus1.raddr_a = 3'd7; bus1.raddr_b = 3'd7;
      push_expect("oob_write_pre");
      tick();
      bus1.wen = 1'b0;
      for (int i = 0; i < 8; i++) begin
         bus1.raddr_a = 3'(i); bus1.raddr_b = 3'd7;
         push_expect($sformatf("oob_sweep%0d", i));
         tick();
      end

      // Randomized traffic on both files.
      for (int n = 0; n < 400; n++) begin
         set_rst(($urandom_range(0, 59) == 0) ? 1'b1 : 1'b0);
         bus0.wen     = 1'($urandom_range(0, 1));
         bus0.waddr   = 2'($urandom_range(0, 3));
         bus0.wdata   = 10'($urandom);
         bus0.raddr_a = ($urandom_range(0, 3) == 0) ? bus0.waddr : 2'($urandom_range(0, 3));
         bus0.raddr_b = 2'($urandom_range(0, 3));
         bus1.wen     = 1'($urandom_range(0, 1));
         bus1.waddr   = 3'($urandom_range(0, 7));
         bus1.wdata   = 16'($urandom);
         bus1.raddr_a = 3'($urandom_range(0, 7));
         bus1.raddr_b = ($urandom_range(0, 3) == 0) ? bus1.waddr : 3'($urandom_range(0, 7));
         push_expect($sformatf("rand%0d", n));
         tick();
      end
      set_rst(1'b0);
      idle_both();

      @(negedge clk);
      #1;
      if (exp_q.size() != 0) begin
         n_checks++;
         $display("FAIL drain: %0d entries left, expected 0", exp_q.size());
      end
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
